// File: rtl/div_arb_pkg.sv
//------------------------------------------------------------------------------
// div_arb_pkg
// Shared types and the round-robin pick function for the divider arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_arb_pkg;

  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;
  localparam int DEF_TAMANYO = 32;
  localparam int DEF_ETAPAS  = 32;

  // idx is sized for the largest supported requester count
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dz;
  } tag_t;

  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 j;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        j = (int'(ptr) + k) % n;
        if (!found && valid[j[IDX_W-1:0]]) begin
          grant[j[IDX_W-1:0]] = 1'b1;
          found               = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_tag_fifo.sv
//------------------------------------------------------------------------------
// div_tag_fifo
// In-order FIFO of issue tags for divisions currently inside the divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_tag_fifo
  import div_arb_pkg::*;
#(
  parameter int DEPTH = 34,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  tag_t             i_tag,
  input  logic             i_pop,
  output tag_t             o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  tag_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_arbiter_rr.sv
//------------------------------------------------------------------------------
// div_arbiter_rr
// Round-robin sharing of one pipelined signed divider among N_REQ requesters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_arbiter_rr
  import div_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TAMANYO = DEF_TAMANYO,
  parameter int ETAPAS  = DEF_ETAPAS
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           REQ_VALID,
  input  logic [N_REQ*TAMANYO-1:0]   REQ_NUM,
  input  logic [N_REQ*TAMANYO-1:0]   REQ_DEN,
  output logic [N_REQ-1:0]           REQ_READY,
  output logic [N_REQ-1:0]           RSP_VALID,
  output logic [TAMANYO-1:0]         RSP_COC,
  output logic [TAMANYO-1:0]         RSP_RES,
  output logic                       RSP_DZ,
  output logic                       PROTO_ERR,
  output logic                       DIV_START,
  output logic [TAMANYO-1:0]         DIV_NUM,
  output logic [TAMANYO-1:0]         DIV_DEN,
  input  logic [TAMANYO-1:0]         DIV_COC,
  input  logic [TAMANYO-1:0]         DIV_RES,
  input  logic                       DIV_DONE
);

  localparam int DEPTH = ETAPAS + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [MAX_REQ-1:0] w_valid_pad;
  logic [MAX_REQ-1:0] w_pick;
  logic [N_REQ-1:0]   w_grant;
  logic               w_xfer;
  logic [IDX_W-1:0]   w_idx;
  logic [TAMANYO-1:0] w_num;
  logic [TAMANYO-1:0] w_den;
  logic               w_den_zero;
  tag_t               w_push_tag;
  tag_t               w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count_unused;
  logic               w_pop;
  logic               w_spurious;
  logic [N_REQ-1:0]   w_rsp_onehot;

  logic [IDX_W-1:0]   r_ptr;
  logic               r_div_start;
  logic [TAMANYO-1:0] r_div_num;
  logic [TAMANYO-1:0] r_div_den;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [TAMANYO-1:0] r_rsp_coc;
  logic [TAMANYO-1:0] r_rsp_res;
  logic               r_rsp_dz;
  logic               r_proto_err;

  always_comb begin
    w_valid_pad              = '0;
    w_valid_pad[N_REQ-1:0]   = REQ_VALID;
  end

  assign w_pick = rr_pick(w_valid_pad, r_ptr, N_REQ);

  generate
    if (N_REQ < MAX_REQ) begin : g_pick_pad
      logic [MAX_REQ-N_REQ-1:0] w_pick_unused;
      assign w_pick_unused = w_pick[MAX_REQ-1:N_REQ];
    end
  endgenerate

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  assign w_grant   = (RST || w_full) ? '0 : w_pick[N_REQ-1:0];
  assign REQ_READY = w_grant;
  assign w_xfer    = |w_grant;

  always_comb begin
    w_idx = '0;
    w_num = '0;
    w_den = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_idx = IDX_W'(i);
        w_num = REQ_NUM[i*TAMANYO +: TAMANYO];
        w_den = REQ_DEN[i*TAMANYO +: TAMANYO];
      end
    end
  end

  assign w_den_zero = (w_den == '0);
  assign w_push_tag = '{idx: w_idx, dz: w_den_zero};
  assign w_pop      = DIV_DONE && !w_empty;
  assign w_spurious = DIV_DONE && w_empty;

  div_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_xfer),
    .i_tag   (w_push_tag),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count_unused),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Zero divisors go through as /1 so the divider hands back the numerator
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr       <= IDX_W'(N_REQ - 1);
      r_div_start <= 1'b0;
      r_div_num   <= '0;
      r_div_den   <= '0;
    end else begin
      r_div_start <= w_xfer;
      if (w_xfer) begin
        r_ptr     <= w_idx;
        r_div_num <= w_num;
        r_div_den <= w_den_zero ? TAMANYO'(1) : w_den;
      end
    end
  end

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rsp_onehot[i] = (w_head.idx == IDX_W'(i));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rsp_valid <= '0;
      r_rsp_coc   <= '0;
      r_rsp_res   <= '0;
      r_rsp_dz    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop ? w_rsp_onehot : '0;
      if (w_pop) begin
        r_rsp_dz  <= w_head.dz;
        r_rsp_coc <= w_head.dz ? '0 : DIV_COC;
        r_rsp_res <= w_head.dz ? DIV_COC : DIV_RES;
      end
      if (w_spurious) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign DIV_START = r_div_start;
  assign DIV_NUM   = r_div_num;
  assign DIV_DEN   = r_div_den;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_COC   = r_rsp_coc;
  assign RSP_RES   = r_rsp_res;
  assign RSP_DZ    = r_rsp_dz;
  assign PROTO_ERR = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter_rr.sv
//------------------------------------------------------------------------------
// tb_div_arbiter_rr
// Bench for div_arbiter_rr with a stall-able in-order divider model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_arbiter_rr;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int ET    = 32;
  localparam int DEPTH = ET + 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ_VALID;
  logic [N*W-1:0] REQ_NUM;
  logic [N*W-1:0] REQ_DEN;
  logic [N-1:0]   REQ_READY;
  logic [N-1:0]   RSP_VALID;
  logic [W-1:0]   RSP_COC;
  logic [W-1:0]   RSP_RES;
  logic           RSP_DZ;
  logic           PROTO_ERR;
  logic           DIV_START;
  logic [W-1:0]   DIV_NUM;
  logic [W-1:0]   DIV_DEN;
  logic [W-1:0]   DIV_COC = '0;
  logic [W-1:0]   DIV_RES = '0;
  logic           DIV_DONE;
  logic           model_done = 1'b0;
  logic           spur_done  = 1'b0;

  assign DIV_DONE = model_done | spur_done;

  div_arbiter_rr #(.N_REQ(N), .TAMANYO(W), .ETAPAS(ET)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_NUM   (REQ_NUM),
    .REQ_DEN   (REQ_DEN),
    .REQ_READY (REQ_READY),
    .RSP_VALID (RSP_VALID),
    .RSP_COC   (RSP_COC),
    .RSP_RES   (RSP_RES),
    .RSP_DZ    (RSP_DZ),
    .PROTO_ERR (PROTO_ERR),
    .DIV_START (DIV_START),
    .DIV_NUM   (DIV_NUM),
    .DIV_DEN   (DIV_DEN),
    .DIV_COC   (DIV_COC),
    .DIV_RES   (DIV_RES),
    .DIV_DONE  (DIV_DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int idx; int num; int den; longint acc; } op_t;
  typedef struct { logic [W-1:0] num; logic [W-1:0] den; } iss_t;
  typedef struct { logic [W-1:0] coc; logic [W-1:0] res; longint due; } dv_t;

  op_t  sb [$];
  iss_t iq [$];
  dv_t  dq [$];

  longint ec          = 0;
  int     n_acc       = 0;
  bit     stall       = 1'b0;
  bit     release_one = 1'b0;
  bit     lat_check   = 1'b1;

  always @(posedge CLK) ec++;

  // In-order divider: result appears ET cycles after START unless stalled
  iss_t m_iss;
  dv_t  m_dv;
  always begin
    @(posedge CLK);
    #2;
    if (RST) begin
      dq.delete();
      model_done = 1'b0;
    end else begin
      if (DIV_START) begin
        chk("issue_expected", 64'(iq.size() > 0), 64'd1);
        if (iq.size() > 0) begin
          m_iss = iq.pop_front();
          chk("div_num", 64'(DIV_NUM), 64'(m_iss.num));
          chk("div_den", 64'(DIV_DEN), 64'(m_iss.den));
        end
        if (DIV_DEN != '0) begin
          m_dv.coc = $signed(DIV_NUM) / $signed(DIV_DEN);
          m_dv.res = $signed(DIV_NUM) % $signed(DIV_DEN);
        end else begin
          m_dv.coc = '0;
          m_dv.res = '0;
        end
        m_dv.due = ec + ET;
        dq.push_back(m_dv);
      end
      model_done = 1'b0;
      if ((!stall || release_one) && dq.size() > 0 && dq[0].due <= ec) begin
        m_dv        = dq.pop_front();
        model_done  = 1'b1;
        DIV_COC     = m_dv.coc;
        DIV_RES     = m_dv.res;
        release_one = 1'b0;
      end
    end
  end

  // Reference: grant rule, outstanding count, response contents and timing
  int           out_cnt  = 0;
  int           last_g   = N - 1;
  bit           exp_perr = 1'b0;
  bit           rsp_pend = 1'b0;
  logic [N-1:0] exp_r;
  logic [N-1:0] acc_v;
  bit           found;
  bit           dec;
  op_t          m_op;
  logic [W-1:0] e_coc;
  logic [W-1:0] e_res;

  always @(negedge CLK) begin
    if (RST) begin
      out_cnt  = 0;
      last_g   = N - 1;
      exp_perr = 1'b0;
      rsp_pend = 1'b0;
      sb.delete();
      iq.delete();
    end else begin
      exp_r = '0;
      found = 1'b0;
      if (out_cnt < DEPTH) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && REQ_VALID[(last_g + k) % N]) begin
            exp_r[(last_g + k) % N] = 1'b1;
            found = 1'b1;
          end
        end
      end
      chk("req_ready", 64'(REQ_READY), 64'(exp_r));
      chk("proto_err", 64'(PROTO_ERR), 64'(exp_perr));

      if (rsp_pend && sb.size() > 0) begin
        m_op = sb.pop_front();
        chk("rsp_valid", 64'(RSP_VALID), 64'(1 << m_op.idx));
        chk("rsp_dz", 64'(RSP_DZ), 64'(m_op.den == 0));
        e_coc = (m_op.den == 0) ? '0 : 32'(m_op.num / m_op.den);
        e_res = (m_op.den == 0) ? 32'(m_op.num) : 32'(m_op.num % m_op.den);
        chk("rsp_coc", 64'(RSP_COC), 64'(e_coc));
        chk("rsp_res", 64'(RSP_RES), 64'(e_res));
        if (lat_check) chk("rsp_latency", 64'(ec), 64'(m_op.acc + ET + 1));
      end else begin
        chk("rsp_idle", 64'(RSP_VALID), 64'd0);
      end
      rsp_pend = 1'b0;

      acc_v = REQ_VALID & REQ_READY;
      if (acc_v != '0) begin
        for (int i = 0; i < N; i++) begin
          if (acc_v[i]) begin
            m_op.idx = i;
            m_op.num = int'($signed(REQ_NUM[i*W +: W]));
            m_op.den = int'($signed(REQ_DEN[i*W +: W]));
            m_op.acc = ec + 1;
            sb.push_back(m_op);
            m_iss.num = REQ_NUM[i*W +: W];
            m_iss.den = (REQ_DEN[i*W +: W] == '0) ? 32'd1 : REQ_DEN[i*W +: W];
            iq.push_back(m_iss);
            last_g = i;
          end
        end
        n_acc++;
      end
      dec = DIV_DONE && (out_cnt > 0);
      if (DIV_DONE) begin
        if (out_cnt > 0) rsp_pend = 1'b1;
        else             exp_perr = 1'b1;
      end
      out_cnt = out_cnt + ((acc_v != '0) ? 1 : 0) - (dec ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input int num, input int den);
    REQ_NUM[i*W +: W] = 32'(num);
    REQ_DEN[i*W +: W] = 32'(den);
  endtask

  task automatic burst(input logic [N-1:0] mask, input int maxc);
    logic [N-1:0] pend;
    pend = mask;
    step();
    REQ_VALID = pend;
    for (int c = 0; c < maxc && pend != '0; c++) begin
      @(negedge CLK);
      pend = pend & ~(REQ_VALID & REQ_READY);
      step();
      REQ_VALID = pend;
    end
    chk("burst_done", 64'(pend), 64'd0);
  endtask

  task automatic wait_rsp(input int idx, input int maxc, output bit seen,
                          output logic [W-1:0] coc, output logic [W-1:0] res, output logic dz);
    seen = 1'b0;
    coc  = '0;
    res  = '0;
    dz   = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge CLK);
      if (RSP_VALID[idx]) begin
        seen = 1'b1;
        coc  = RSP_COC;
        res  = RSP_RES;
        dz   = RSP_DZ;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  bit           seen;
  logic [W-1:0] r_coc;
  logic [W-1:0] r_res;
  logic         r_dz;
  int           a0;
  int           num;
  int           den;

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_NUM   = '0;
    REQ_DEN   = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready", 64'(REQ_READY), 64'd0);
    chk("reset_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("reset_div_start", 64'(DIV_START), 64'd0);
    chk("reset_proto_err", 64'(PROTO_ERR), 64'd0);
    RST = 1'b0;

    // four requesters valid from reset: grants rotate 0,1,2,3,0
    set_req(0, 4, 2);
    set_req(1, -5, 3);
    set_req(2, 5, -3);
    set_req(3, -6, -3);
    REQ_VALID = 4'hF;
    for (int g = 0; g < 5; g++) begin
      @(negedge CLK);
      chk("t2_grant", 64'(REQ_READY), 64'(1 << (g % 4)));
      step();
    end
    REQ_VALID = '0;
    repeat (ET + 6) @(negedge CLK);

    // single request 7/2
    set_req(0, 7, 2);
    burst(4'b0001, 10);
    wait_rsp(0, ET + 5, seen, r_coc, r_res, r_dz);
    chk("t1_seen", 64'(seen), 64'd1);
    chk("t1_coc", 64'(r_coc), 64'd3);
    chk("t1_res", 64'(r_res), 64'd1);
    chk("t1_dz", 64'(r_dz), 64'd0);

    // divide by zero between neighbours
    set_req(1, 10, 3);
    set_req(2, 9, 0);
    set_req(3, -7, 2);
    burst(4'b1110, 10);
    wait_rsp(2, ET + 6, seen, r_coc, r_res, r_dz);
    chk("t3_seen", 64'(seen), 64'd1);
    chk("t3_dz", 64'(r_dz), 64'd1);
    chk("t3_coc", 64'(r_coc), 64'd0);
    chk("t3_res", 64'(r_res), 64'd9);
    repeat (6) @(negedge CLK);

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        num = int'($urandom_range(0, 2000)) - 1000;
        if ($urandom_range(0, 7) == 0) den = 0;
        else den = int'($urandom_range(1, 50)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
        set_req(i, num, den);
      end
      REQ_VALID = 4'($urandom_range(0, 15));
    end
    step();
    REQ_VALID = '0;
    repeat (ET + 6) @(negedge CLK);
    chk("rand_drained", 64'(sb.size()), 64'd0);

    // spurious DONE with nothing outstanding
    step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t6_perr_set", 64'(PROTO_ERR), 64'd1);
    repeat (5) @(negedge CLK);
    chk("t6_perr_sticky", 64'(PROTO_ERR), 64'd1);

    // fill the tag FIFO with the divider stalled
    lat_check = 1'b0;
    stall     = 1'b1;
    a0        = n_acc;
    step();
    set_req(1, 100, 7);
    REQ_VALID = 4'b0010;
    repeat (45) step();
    @(negedge CLK);
    chk("t4_accepts_full", 64'(n_acc - a0), 64'd34);
    chk("t4_ready_full", 64'(REQ_READY), 64'd0);
    step();
    release_one = 1'b1;
    repeat (4) step();
    @(negedge CLK);
    chk("t4_accepts_freed", 64'(n_acc - a0), 64'd35);
    chk("t4_ready_refull", 64'(REQ_READY), 64'd0);
    step();
    REQ_VALID = '0;

    // asynchronous reset with tags in flight
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("t5_div_num", 64'(DIV_NUM), 64'd0);
    chk("t5_div_den", 64'(DIV_DEN), 64'd0);
    chk("t5_rsp_coc", 64'(RSP_COC), 64'd0);
    chk("t5_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("t5_perr", 64'(PROTO_ERR), 64'd0);
    stall = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    lat_check = 1'b1;
    set_req(0, -20, 6);
    set_req(3, 20, -6);
    REQ_VALID = 4'b1001;
    @(negedge CLK);
    chk("t5_first", 64'(REQ_READY), 64'b0001);
    step();
    REQ_VALID = 4'b1000;
    @(negedge CLK);
    chk("t5_second", 64'(REQ_READY), 64'b1000);
    step();
    REQ_VALID = '0;
    repeat (ET + 6) @(negedge CLK);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
